// File: rtl/exe_mem_pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// exe_mem_pipe_reg_pkg
// Shared pipeline definitions for the EXE/MEM stage register and its ID/EX and
// MEM/WB siblings.
//   occ_state_e  : occupancy state encoding (value equals the entry count)
//   pipe_ctrl_t  : write-back / memory control bits carried with every entry
//   gate_ctrl    : forces control bits low for a bubble
//   payload_width: packed width of a full stage payload for given data widths
// The full payload struct depends on the stage's width parameters, so each
// stage declares it locally around pipe_ctrl_t.
// -----------------------------------------------------------------------------
package exe_mem_pipe_reg_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
  } pipe_ctrl_t;

  localparam int PIPE_CTRL_W = 3;

  // Bubbles must never expose stale enables to forwarding/hazard logic.
  function automatic pipe_ctrl_t gate_ctrl(input pipe_ctrl_t ctrl, input logic valid);
    if (valid) begin
      return ctrl;
    end else begin
      return pipe_ctrl_t'(3'b000);
    end
  endfunction

  function automatic int payload_width(input int data_w, input int reg_addr_w);
    return PIPE_CTRL_W + (2 * data_w) + reg_addr_w;
  endfunction

endpackage

// File: rtl/exe_mem_pipe_reg_skid.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic valid/ready buffer with flush, holding up to two entries (SKID=1,
// registered o_ready) or one entry (SKID=0, o_ready combinational from i_ready).
// Ports:
//   i_clk, i_rst (sync, active-low), i_flush
//   i_valid / o_ready / i_data  : upstream handshake and payload
//   o_valid / i_ready / o_data  : downstream handshake and head payload
//   o_state                     : occupancy state (EMPTY / ONE / TWO)
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import exe_mem_pipe_reg_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output occ_state_e   o_state
);

  occ_state_e   r_state;
  occ_state_e   w_state_nxt;
  logic [W-1:0] r_head;
  logic [W-1:0] r_skid;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_load_head_in;
  logic         w_load_head_skid;
  logic         w_load_skid;

  // Handshake outputs decoded from the state register.
  // With SKID=0 the single entry can be replaced while it leaves, so ready
  // follows the downstream ready; TWO is unreachable in that mode.
  always_comb begin
    o_valid = (r_state != OCC_EMPTY);
    if (SKID) begin
      o_ready = (r_state != OCC_TWO);
    end else begin
      o_ready = (r_state == OCC_EMPTY) | i_ready;
    end
  end

  assign w_in_fire  = i_valid & o_ready;
  assign w_out_fire = o_valid & i_ready;

  // Next-state and load-enable decode; flush discards everything, including
  // a same-cycle input.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (i_flush) begin
      w_state_nxt = OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt    = OCC_ONE;
            w_load_head_in = 1'b1;
          end else begin
            w_state_nxt = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_state_nxt    = OCC_ONE;
            w_load_head_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = OCC_TWO;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = OCC_EMPTY;
          end else begin
            w_state_nxt = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (w_out_fire) begin
            w_state_nxt      = OCC_ONE;
            w_load_head_skid = 1'b1;
          end else begin
            w_state_nxt = OCC_TWO;
          end
        end
        default: begin
          w_state_nxt = OCC_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload registers; reset and flush zero them so no partial entry survives.
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_flush) begin
      r_head <= {W{1'b0}};
      r_skid <= {W{1'b0}};
    end else begin
      if (w_load_head_in) begin
        r_head <= i_data;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

  assign o_data  = r_head;
  assign o_state = r_state;

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// exe_mem_pipe_reg
// EXE->MEM pipeline register with valid/ready flow control, flush and an
// optional two-entry skid buffer.
// Ports:
//   i_clk, i_rst (sync, active-low), i_flush
//   i_in_valid / o_in_ready          : execute-stage handshake
//   i_in_wb_en, i_in_mem_r_en, i_in_mem_w_en, i_in_alu_result,
//   i_in_wb_reg_dest, i_in_val_rm    : incoming payload
//   o_out_valid / i_out_ready        : memory-stage handshake
//   o_out_*                          : head payload, control bits gated by valid
//   o_occupancy                      : held entries (0..2)
// -----------------------------------------------------------------------------
module exe_mem_pipe_reg
  import exe_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter bit SKID       = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic                  i_in_wb_en,
  input  logic                  i_in_mem_r_en,
  input  logic                  i_in_mem_w_en,
  input  logic [DATA_W-1:0]     i_in_alu_result,
  input  logic [REG_ADDR_W-1:0] i_in_wb_reg_dest,
  input  logic [DATA_W-1:0]     i_in_val_rm,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_wb_en,
  output logic                  o_out_mem_r_en,
  output logic                  o_out_mem_w_en,
  output logic [DATA_W-1:0]     o_out_alu_result,
  output logic [REG_ADDR_W-1:0] o_out_wb_reg_dest,
  output logic [DATA_W-1:0]     o_out_val_rm,
  output logic [1:0]            o_occupancy
);

  typedef struct packed {
    pipe_ctrl_t            ctrl;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] wb_reg_dest;
    logic [DATA_W-1:0]     val_rm;
  } payload_t;

  localparam int PAYLOAD_W = payload_width(DATA_W, REG_ADDR_W);

  payload_t               w_in_pl;
  payload_t               w_head_pl;
  logic [PAYLOAD_W-1:0]   w_in_bits;
  logic [PAYLOAD_W-1:0]   w_head_bits;
  logic                   w_out_valid;
  occ_state_e             w_state;
  pipe_ctrl_t             w_ctrl_gated;

  // Pack the execute-stage fields into one payload word.
  always_comb begin
    w_in_pl.ctrl.wb_en    = i_in_wb_en;
    w_in_pl.ctrl.mem_r_en = i_in_mem_r_en;
    w_in_pl.ctrl.mem_w_en = i_in_mem_w_en;
    w_in_pl.alu_result    = i_in_alu_result;
    w_in_pl.wb_reg_dest   = i_in_wb_reg_dest;
    w_in_pl.val_rm        = i_in_val_rm;
  end

  assign w_in_bits = w_in_pl;
  assign w_head_pl = payload_t'(w_head_bits);

  pipe_skid_buf #(
    .W    (PAYLOAD_W),
    .SKID (SKID)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_in_valid),
    .o_ready (o_in_ready),
    .i_data  (w_in_bits),
    .o_valid (w_out_valid),
    .i_ready (i_out_ready),
    .o_data  (w_head_bits),
    .o_state (w_state)
  );

  assign w_ctrl_gated = gate_ctrl(w_head_pl.ctrl, w_out_valid);

  // Unpack the head entry; data fields are held, control fields gated.
  always_comb begin
    o_out_valid       = w_out_valid;
    o_out_wb_en       = w_ctrl_gated.wb_en;
    o_out_mem_r_en    = w_ctrl_gated.mem_r_en;
    o_out_mem_w_en    = w_ctrl_gated.mem_w_en;
    o_out_alu_result  = w_head_pl.alu_result;
    o_out_wb_reg_dest = w_head_pl.wb_reg_dest;
    o_out_val_rm      = w_head_pl.val_rm;
    o_occupancy       = w_state;
  end

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
module tb_exe_mem_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: SKID=1, DATA_W=32, REG_ADDR_W=4
  logic        a_rst, a_flush, a_in_valid, a_in_ready;
  logic        a_wb, a_mr, a_mw;
  logic [31:0] a_alu, a_rm;
  logic [3:0]  a_dest;
  logic        a_out_valid, a_out_ready, a_o_wb, a_o_mr, a_o_mw;
  logic [31:0] a_o_alu, a_o_rm;
  logic [3:0]  a_o_dest;
  logic [1:0]  a_occ;

  // DUT B: SKID=0, DATA_W=64, REG_ADDR_W=5
  logic        b_rst, b_flush, b_in_valid, b_in_ready;
  logic        b_wb, b_mr, b_mw;
  logic [63:0] b_alu, b_rm;
  logic [4:0]  b_dest;
  logic        b_out_valid, b_out_ready, b_o_wb, b_o_mr, b_o_mw;
  logic [63:0] b_o_alu, b_o_rm;
  logic [4:0]  b_o_dest;
  logic [1:0]  b_occ;

  exe_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(4), .SKID(1'b1)) u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_flush(a_flush),
    .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_in_wb_en(a_wb), .i_in_mem_r_en(a_mr), .i_in_mem_w_en(a_mw),
    .i_in_alu_result(a_alu), .i_in_wb_reg_dest(a_dest), .i_in_val_rm(a_rm),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready),
    .o_out_wb_en(a_o_wb), .o_out_mem_r_en(a_o_mr), .o_out_mem_w_en(a_o_mw),
    .o_out_alu_result(a_o_alu), .o_out_wb_reg_dest(a_o_dest), .o_out_val_rm(a_o_rm),
    .o_occupancy(a_occ)
  );

  exe_mem_pipe_reg #(.DATA_W(64), .REG_ADDR_W(5), .SKID(1'b0)) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_flush(b_flush),
    .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_in_wb_en(b_wb), .i_in_mem_r_en(b_mr), .i_in_mem_w_en(b_mw),
    .i_in_alu_result(b_alu), .i_in_wb_reg_dest(b_dest), .i_in_val_rm(b_rm),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
    .o_out_wb_en(b_o_wb), .o_out_mem_r_en(b_o_mr), .o_out_mem_w_en(b_o_mw),
    .o_out_alu_result(b_o_alu), .o_out_wb_reg_dest(b_o_dest), .o_out_val_rm(b_o_rm),
    .o_occupancy(b_occ)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_rst = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_wb = 1'b1; a_mr = 1'b1; a_mw = 1'b1;
    a_alu = 32'h55; a_rm = 32'h5; a_dest = 4'd5;
    b_rst = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_wb = 1'b1; b_mr = 1'b0; b_mw = 1'b0;
    b_alu = 64'h99; b_rm = 64'h0; b_dest = 5'd1;

    // Reset held for two edges with in_valid asserted
    tick(); tick();
    check("rst_a_valid", a_out_valid, 1'b0);
    check("rst_a_wb", a_o_wb, 1'b0);
    check("rst_a_mw", a_o_mw, 1'b0);
    check("rst_a_alu", a_o_alu, 32'h0);
    check("rst_a_dest", a_o_dest, 4'h0);
    check("rst_a_in_ready", a_in_ready, 1'b1);
    check("rst_a_occ", a_occ, 2'd0);
    check("rst_b_valid", b_out_valid, 1'b0);
    check("rst_b_alu", b_o_alu, 64'h0);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    check("rst_b_occ", b_occ, 2'd0);

    // Streaming with out_ready=1
    b_in_valid = 1'b0; b_rst = 1'b1;
    a_rst = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1;
    a_wb = 1'b1; a_mr = 1'b0; a_mw = 1'b0; a_dest = 4'd3;
    a_alu = 32'h10; a_rm = 32'hAAAA0001;
    tick();
    check("str_valid0", a_out_valid, 1'b1);
    check("str_alu0", a_o_alu, 32'h10);
    check("str_rm0", a_o_rm, 32'hAAAA0001);
    check("str_wb0", a_o_wb, 1'b1);
    check("str_occ0", a_occ, 2'd1);
    a_alu = 32'h20; a_rm = 32'hAAAA0002;
    tick();
    check("str_valid1", a_out_valid, 1'b1);
    check("str_alu1", a_o_alu, 32'h20);
    check("str_occ1", a_occ, 2'd1);
    a_alu = 32'h30; a_rm = 32'hAAAA0003;
    tick();
    check("str_alu2", a_o_alu, 32'h30);
    check("str_rm2", a_o_rm, 32'hAAAA0003);
    check("str_occ2", a_occ, 2'd1);
    a_in_valid = 1'b0;
    tick();
    check("str_drain_valid", a_out_valid, 1'b0);
    check("str_drain_wb", a_o_wb, 1'b0);
    check("str_drain_occ", a_occ, 2'd0);
    check("str_drain_alu_held", a_o_alu, 32'h30);

    // Backpressure filling the skid entry
    a_in_valid = 1'b1; a_alu = 32'hA0;
    tick();
    check("bp_load_a0", a_o_alu, 32'hA0);
    a_out_ready = 1'b0; a_alu = 32'hB0;
    tick();
    check("bp_occ2", a_occ, 2'd2);
    check("bp_in_ready0", a_in_ready, 1'b0);
    check("bp_head_a0", a_o_alu, 32'hA0);
    a_in_valid = 1'b0;
    tick();
    check("bp_stable_alu", a_o_alu, 32'hA0);
    check("bp_stable_valid", a_out_valid, 1'b1);
    a_out_ready = 1'b1;
    tick();
    check("bp_deliver_b0", a_o_alu, 32'hB0);
    check("bp_occ1", a_occ, 2'd1);
    check("bp_in_ready1", a_in_ready, 1'b1);
    tick();
    check("bp_empty_valid", a_out_valid, 1'b0);
    check("bp_empty_occ", a_occ, 2'd0);

    // Flush with two held entries and an incoming store
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_alu = 32'h11;
    tick();
    a_alu = 32'h22;
    tick();
    check("fl_pre_occ", a_occ, 2'd2);
    a_alu = 32'h33; a_mw = 1'b1; a_flush = 1'b1;
    tick();
    check("fl_valid", a_out_valid, 1'b0);
    check("fl_mw", a_o_mw, 1'b0);
    check("fl_occ", a_occ, 2'd0);
    check("fl_alu_cleared", a_o_alu, 32'h0);
    check("fl_in_ready", a_in_ready, 1'b1);
    a_flush = 1'b0; a_in_valid = 1'b0; a_mw = 1'b0; a_out_ready = 1'b1;
    tick();
    check("fl_no_deliver", a_out_valid, 1'b0);
    // Flush beats a same-cycle input fire into an empty stage
    a_in_valid = 1'b1; a_alu = 32'h44; a_flush = 1'b1;
    tick();
    check("fl_fire_valid", a_out_valid, 1'b0);
    check("fl_fire_alu", a_o_alu, 32'h0);
    a_flush = 1'b0; a_in_valid = 1'b0;

    // Reset in the middle of backpressure
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_mr = 1'b1; a_alu = 32'h66; a_dest = 4'd9;
    tick();
    a_alu = 32'h77;
    tick();
    check("mr_pre_occ", a_occ, 2'd2);
    a_rst = 1'b0; a_in_valid = 1'b0;
    tick();
    check("mr_valid", a_out_valid, 1'b0);
    check("mr_mr", a_o_mr, 1'b0);
    check("mr_alu", a_o_alu, 32'h0);
    check("mr_dest", a_o_dest, 4'h0);
    check("mr_occ", a_occ, 2'd0);
    check("mr_in_ready", a_in_ready, 1'b1);
    a_rst = 1'b1; a_in_valid = 1'b1; a_alu = 32'h88; a_out_ready = 1'b1;
    tick();
    check("mr_after_valid", a_out_valid, 1'b1);
    check("mr_after_alu", a_o_alu, 32'h88);
    check("mr_after_mr", a_o_mr, 1'b1);
    a_in_valid = 1'b0;
    tick();
    check("mr_after_drain", a_out_valid, 1'b0);

    // SKID=0: combinational ready and same-cycle head replacement
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_alu = 64'h1111; b_dest = 5'd2; b_wb = 1'b1;
    #1;
    check("s0_ready_empty", b_in_ready, 1'b1);
    tick();
    check("s0_full_valid", b_out_valid, 1'b1);
    check("s0_full_alu", b_o_alu, 64'h1111);
    check("s0_full_occ", b_occ, 2'd1);
    b_alu = 64'hFFFF_0000_1234_5678; b_dest = 5'd31;
    #1;
    check("s0_ready_full", b_in_ready, 1'b0);
    tick();
    check("s0_hold_alu", b_o_alu, 64'h1111);
    b_out_ready = 1'b1;
    #1;
    check("s0_ready_comb", b_in_ready, 1'b1);
    tick();
    check("s0_repl_alu", b_o_alu, 64'hFFFF_0000_1234_5678);
    check("s0_repl_dest", b_o_dest, 5'd31);
    check("s0_repl_valid", b_out_valid, 1'b1);
    check("s0_repl_occ", b_occ, 2'd1);
    b_in_valid = 1'b0;
    tick();
    check("s0_drain_valid", b_out_valid, 1'b0);
    check("s0_drain_wb", b_o_wb, 1'b0);
    check("s0_drain_occ", b_occ, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
